// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RISC-V control FSM.
// The upper-immediate instructions (lui/auipc) and their EXECU state exist
// only when CTRL_UPPER_IMM_EN is defined.
package ctrl_pkg;

  // FSM state encoding; values are fixed so they stay stable across builds.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_ERROR    = 4'd14
`ifdef CTRL_UPPER_IMM_EN
    ,
    S_EXECU    = 4'd13
`endif
  } state_t;

  // Instr[6:0] opcodes.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALUControl.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // ALUOp: how the ALU decoder should pick ALUControl.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcA.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALUSrcB.
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ResultSrc.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ImmSrc.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Only beq (000) and bne (001) are supported branch conditions.
  function automatic logic branch_supported(input logic [2:0] funct3);
    return (funct3 == 3'b000) || (funct3 == 3'b001);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus instruction funct fields to ALUControl.
// illegal flags funct combinations the ALU cannot execute (funct3 011, and
// 101 with funct7b5 set); it does not depend on ALUOp so the FSM can screen
// the instruction during DECODE while the ALU is still doing an add.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       illegal
);

  // Unsupported funct encodings.
  always_comb begin
    illegal = (funct3 == 3'b011) || ((funct3 == 3'b101) && funct7b5);
  end

  // ALU operation select; sub only for R-type (op5) with funct7b5.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b100:  alu_control = ALU_XOR;
          3'b010:  alu_control = ALU_SLT;
          3'b001:  alu_control = ALU_SLL;
          3'b101:  alu_control = ALU_SRL;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: Moore control unit for a multicycle RV32 subset datapath.
// Outputs depend on state only, except PCWrite in BRANCH (zero flag),
// ALUControl in EXECR/EXECI (funct fields) and ImmSrc in DECODE (opcode).
// Store-vs-load and lui-vs-auipc are captured in DECODE so MEMADR/EXECU
// outputs remain pure functions of registered state.
// Optional feature: define CTRL_UPPER_IMM_EN to support lui/auipc via EXECU;
// otherwise both opcodes are treated as illegal.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal
);

  state_t     state_p1;
  state_t     state_nxt;
  logic       is_store_p1;
`ifdef CTRL_UPPER_IMM_EN
  logic       is_lui_p1;
`endif
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl_dec;
  logic       funct_illegal;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_ctrl_dec),
    .illegal     (funct_illegal)
  );

  // Next-state selection; the opcode dispatch happens in DECODE.
  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD,
          OP_STORE:  state_nxt = S_MEMADR;
          OP_RTYPE:  state_nxt = funct_illegal ? S_ERROR : S_EXECR;
          OP_ITYPE:  state_nxt = funct_illegal ? S_ERROR : S_EXECI;
          OP_BRANCH: state_nxt = branch_supported(funct3) ? S_BRANCH : S_ERROR;
          OP_JAL:    state_nxt = S_JAL;
          OP_JALR:   state_nxt = S_JALR;
`ifdef CTRL_UPPER_IMM_EN
          OP_LUI,
          OP_AUIPC:  state_nxt = S_EXECU;
`endif
          default:   state_nxt = S_ERROR;
        endcase
      end
      S_MEMADR:   state_nxt = is_store_p1 ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = S_FETCH;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_JALR:     state_nxt = S_LINK;
      S_LINK:     state_nxt = S_ALUWB;
`ifdef CTRL_UPPER_IMM_EN
      S_EXECU:    state_nxt = S_ALUWB;
`endif
      S_ERROR:    state_nxt = S_ERROR;
      default:    state_nxt = S_ERROR;
    endcase
  end

  // State register; reset always restarts at FETCH, abandoning any instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= S_FETCH;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Instruction-kind flags captured in DECODE for later state outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_p1 <= 1'b0;
`ifdef CTRL_UPPER_IMM_EN
      is_lui_p1   <= 1'b0;
`endif
    end else if (state_p1 == S_DECODE) begin
      is_store_p1 <= (op == OP_STORE);
`ifdef CTRL_UPPER_IMM_EN
      is_lui_p1   <= (op == OP_LUI);
`endif
    end
  end

  // ALU decoder mode per state.
  always_comb begin
    case (state_p1)
      S_EXECR,
      S_EXECI:  alu_op = ALUOP_FUNCT;
      S_BRANCH: alu_op = ALUOP_SUB;
      default:  alu_op = ALUOP_ADD;
    endcase
  end

  // Output decode; everything forced low while rst is held.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUControl = alu_ctrl_dec;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ImmSrc     = IMM_I;
    RegWrite   = 1'b0;
    illegal    = 1'b0;
    case (state_p1)
      S_FETCH: begin
        AdrSrc    = 1'b0;
        IRWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        // Branch/jump target into ALUOut ahead of knowing the instruction.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = is_store_p1 ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_RS2;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        // funct3[0] distinguishes bne from beq.
        PCWrite   = funct3[0] ? ~zero : zero;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_I;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
      end
      S_LINK: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
      end
`ifdef CTRL_UPPER_IMM_EN
      S_EXECU: begin
        ALUSrcA = is_lui_p1 ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
`endif
      S_ERROR: begin
        ALUControl = ALU_ADD;
        illegal    = 1'b1;
      end
      default: begin
        ALUControl = ALU_ADD;
      end
    endcase
    if (rst) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUControl = 3'b000;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 3'b000;
      RegWrite   = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench for control_fsm. The driver expands each
// instruction into its expected per-cycle control words from the
// instruction-set rules and queues them; a negedge monitor pops and compares.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [2:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] imm;
    logic       rw;
    logic       ill;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t seq_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic out_t rec(input logic pcw, input logic adr, input logic mw,
                               input logic irw, input logic [1:0] rs,
                               input logic [2:0] alu, input logic [1:0] sa,
                               input logic [1:0] sb, input logic [2:0] imm,
                               input logic rw, input logic ill);
    out_t r;
    r.pcw = pcw; r.adr = adr; r.mw = mw; r.irw = irw; r.rs = rs; r.alu = alu;
    r.sa = sa; r.sb = sb; r.imm = imm; r.rw = rw; r.ill = ill;
    return r;
  endfunction

  function automatic void add_seq(input out_t v, input string tag);
    exp_t e;
    e.v = v;
    e.tag = tag;
    seq_q.push_back(e);
  endfunction

  // Reference ALU operation for ALU-class instructions; ok=0 when unsupported.
  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic f7,
                                         input logic is_r, output logic ok);
    ok = 1'b1;
    case (f3)
      3'd0: return (is_r && f7) ? 3'd1 : 3'd0;
      3'd7: return 3'd2;
      3'd6: return 3'd3;
      3'd4: return 3'd4;
      3'd2: return 3'd5;
      3'd1: return 3'd6;
      3'd5: begin ok = !f7; return 3'd7; end
      default: begin ok = 1'b0; return 3'd0; end
    endcase
  endfunction

  // Build the full expected control sequence of one instruction into seq_q.
  task automatic model_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int n_err,
                             output logic err);
    out_t  aluwb;
    logic  ok;
    logic [2:0] a;
    seq_q.delete();
    err = 1'b0;
    aluwb = rec(0,0,0,0,2'b00,3'd0,2'b00,2'b00,3'd0,1,0);
    add_seq(rec(1,0,0,1,2'b10,3'd0,2'b00,2'b10,3'd0,0,0), "FETCH");
    add_seq(rec(0,0,0,0,2'b00,3'd0,2'b01,2'b01,(o == 7'h6F) ? 3'd3 : 3'd2,0,0), "DECODE");
    case (o)
      7'h03: begin
        add_seq(rec(0,0,0,0,2'b00,3'd0,2'b10,2'b01,3'd0,0,0), "MEMADR");
        add_seq(rec(0,1,0,0,2'b00,3'd0,2'b00,2'b00,3'd0,0,0), "MEMREAD");
        add_seq(rec(0,0,0,0,2'b01,3'd0,2'b00,2'b00,3'd0,1,0), "MEMWB");
      end
      7'h23: begin
        add_seq(rec(0,0,0,0,2'b00,3'd0,2'b10,2'b01,3'd1,0,0), "MEMADR");
        add_seq(rec(0,1,1,0,2'b00,3'd0,2'b00,2'b00,3'd0,0,0), "MEMWRITE");
      end
      7'h33, 7'h13: begin
        a = alu_ref(f3, f7, o == 7'h33, ok);
        if (!ok) err = 1'b1;
        else begin
          add_seq(rec(0,0,0,0,2'b00,a,2'b10,(o == 7'h33) ? 2'b00 : 2'b01,3'd0,0,0), "EXEC");
          add_seq(aluwb, "ALUWB");
        end
      end
      7'h63: begin
        if (f3 == 3'd0 || f3 == 3'd1)
          add_seq(rec((f3 == 3'd0) ? z : !z,0,0,0,2'b00,3'd1,2'b10,2'b00,3'd0,0,0), "BRANCH");
        else err = 1'b1;
      end
      7'h6F: begin
        add_seq(rec(1,0,0,0,2'b00,3'd0,2'b01,2'b10,3'd0,0,0), "JAL");
        add_seq(aluwb, "ALUWB");
      end
      7'h67: begin
        add_seq(rec(1,0,0,0,2'b10,3'd0,2'b10,2'b01,3'd0,0,0), "JALR");
        add_seq(rec(0,0,0,0,2'b00,3'd0,2'b01,2'b10,3'd0,0,0), "LINK");
        add_seq(aluwb, "ALUWB");
      end
`ifdef CTRL_UPPER_IMM_EN
      7'h37, 7'h17: begin
        add_seq(rec(0,0,0,0,2'b00,3'd0,(o == 7'h37) ? 2'b11 : 2'b01,2'b01,3'd4,0,0), "EXECU");
        add_seq(aluwb, "ALUWB");
      end
`endif
      default: err = 1'b1;
    endcase
    if (err)
      for (int i = 0; i < n_err; i++)
        add_seq(rec(0,0,0,0,2'b00,3'd0,2'b00,2'b00,3'd0,0,1), "ERROR");
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    rst = 1'b1;
    e.v = '0;
    e.tag = "RESET";
    for (int i = 0; i < n; i++) exp_q.push_back(e);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issue one instruction; keep < 0 runs it fully, otherwise reset after
  // keep cycles to abandon it.
  task automatic run(input logic [31:0] w, input logic z, input int n_err,
                     input int keep);
    logic err;
    int   n;
    op = w[6:0];
    funct3 = w[14:12];
    funct7b5 = w[30];
    zero = z;
    model_instr(w[6:0], w[14:12], w[30], z, n_err, err);
    n = seq_q.size();
    if (keep >= 0 && keep < n) n = keep;
    for (int i = 0; i < n; i++) exp_q.push_back(seq_q[i]);
    repeat (n) @(posedge clk);
    #1;
    if (err || (keep >= 0 && keep < seq_q.size())) do_reset(2);
  endtask

  // Monitor: compare every presented control word with the queued one.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      out_t act;
      e = exp_q.pop_front();
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
             ALUSrcA, ALUSrcB, ImmSrc, RegWrite, illegal};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s @%0t: got pcw=%b adr=%b mw=%b irw=%b rs=%b alu=%b sa=%b sb=%b imm=%b rw=%b ill=%b, want pcw=%b adr=%b mw=%b irw=%b rs=%b alu=%b sa=%b sb=%b imm=%b rw=%b ill=%b",
                 e.tag, $time, act.pcw, act.adr, act.mw, act.irw, act.rs, act.alu,
                 act.sa, act.sb, act.imm, act.rw, act.ill, e.v.pcw, e.v.adr, e.v.mw,
                 e.v.irw, e.v.rs, e.v.alu, e.v.sa, e.v.sb, e.v.imm, e.v.rw, e.v.ill);
      end
    end
  end

  logic [6:0] valid_ops [9];

  initial begin
    logic [31:0] w;
    rst = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
    valid_ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    @(posedge clk);
    #1;
    do_reset(3);

    run(32'h002081B3, 1'b0, 3, -1);   // add
    run(32'h402081B3, 1'b1, 3, -1);   // sub
    run(32'h0000A183, 1'b0, 3, -1);   // lw
    run(32'h0020A223, 1'b0, 3, -1);   // sw
    run(32'h00208463, 1'b1, 3, -1);   // beq taken
    run(32'h00208463, 1'b0, 3, -1);   // beq not taken
    run(32'h00209463, 1'b1, 3, -1);   // bne, zero=1
    run(32'h00209463, 1'b0, 3, -1);   // bne, zero=0
    run(32'h008000EF, 1'b0, 3, -1);   // jal
    run(32'h000080E7, 1'b0, 3, -1);   // jalr
    run(32'h00108093, 1'b0, 3, -1);   // addi
    run(32'h4010D093, 1'b0, 3, -1);   // srai: unsupported
    run(32'h0000007F, 1'b0, 10, -1);  // unknown opcode
    run(32'h0020A223, 1'b0, 3, 2);    // sw abandoned in MEMADR
    run(32'h123450B7, 1'b0, 3, -1);   // lui
    run(32'h00001097, 1'b0, 3, -1);   // auipc
    run(32'h002081B3, 1'b1, 3, -1);   // add after all the above

    for (int k = 0; k < 200; k++) begin
      int sel;
      int keep;
      sel = $urandom_range(0, 9);
      w = $urandom;
      if (sel < 9) w[6:0] = valid_ops[sel];
      keep = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : -1;
      run(w, 1'($urandom_range(0, 1)), $urandom_range(1, 4), keep);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
